// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage PC generator with a direct-mapped BTB, flush recovery and stall hold.
// Optional FETCH_STATS_EN adds saturating redirect/flush counters.
module fetch_pc_sequencer #(
    parameter int                       ADDRESS_WIDTH = 22,
    parameter int                       BTB_ENTRIES   = 16,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     i_Stall,
    input  logic                     i_BP_taken,
    input  logic                     i_BP_valid,
    input  logic                     i_ALU_flush,
    input  logic                     i_ALU_isbranch,
    input  logic                     i_ALU_outcome,
    input  logic [ADDRESS_WIDTH-1:0] i_ALU_pc,
    input  logic [ADDRESS_WIDTH-1:0] i_ALU_target,
`ifdef FETCH_STATS_EN
    output logic [15:0]              o_redirect_count,
    output logic [15:0]              o_flush_count,
`endif
    output logic [ADDRESS_WIDTH-1:0] o_IMEM_address,
    output logic                     o_IMEM_valid,
    output logic                     o_pred_taken,
    output logic                     o_btb_hit
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDRESS_WIDTH - IDX_W;
    localparam logic [ADDRESS_WIDTH-1:0] PC_ONE = ADDRESS_WIDTH'(1);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HOLD,
        S_RECOVER
    } state_t;

    state_t                   r_state;
    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic                     r_valid;

    logic                     r_btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0]         r_btb_tag    [BTB_ENTRIES];
    logic [ADDRESS_WIDTH-1:0] r_btb_target [BTB_ENTRIES];

    logic [IDX_W-1:0]         w_idx;
    logic [TAG_W-1:0]         w_tag;
    logic [IDX_W-1:0]         w_wr_idx;
    logic [TAG_W-1:0]         w_wr_tag;
    logic                     w_btb_we;
    logic                     w_btb_hit;
    logic                     w_redirect;
    logic [ADDRESS_WIDTH-1:0] w_pc_inc;
    logic [ADDRESS_WIDTH-1:0] w_corrected;
    logic [ADDRESS_WIDTH-1:0] w_next_pc;

    assign w_idx      = r_pc[IDX_W-1:0];
    assign w_tag      = r_pc[ADDRESS_WIDTH-1:IDX_W];
    assign w_wr_idx   = i_ALU_pc[IDX_W-1:0];
    assign w_wr_tag   = i_ALU_pc[ADDRESS_WIDTH-1:IDX_W];
    assign w_btb_we   = i_ALU_isbranch & i_ALU_outcome;

    // Lookup reads registered BTB state, so a same-cycle write is seen only next cycle.
    assign w_btb_hit  = r_valid & r_btb_valid[w_idx] & (r_btb_tag[w_idx] == w_tag);
    assign w_redirect = w_btb_hit & i_BP_valid & i_BP_taken;

    assign w_pc_inc    = r_pc + PC_ONE;
    assign w_corrected = i_ALU_outcome ? i_ALU_target : (i_ALU_pc + PC_ONE);
    assign w_next_pc   = w_redirect ? r_btb_target[w_idx] : w_pc_inc;

    assign o_IMEM_address = r_pc;
    assign o_IMEM_valid   = r_valid;
    assign o_btb_hit      = w_btb_hit;
    assign o_pred_taken   = w_redirect;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state <= S_RUN;
                    r_pc    <= w_pc_inc;
                    r_valid <= 1'b1;
                end
                S_RUN, S_HOLD: begin
                    if (i_ALU_flush) begin
                        r_state <= S_RECOVER;
                        r_pc    <= w_corrected;
                        r_valid <= 1'b0;
                    end else if (i_Stall) begin
                        r_state <= S_HOLD;
                        r_valid <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                        r_pc    <= w_next_pc;
                        r_valid <= 1'b1;
                    end
                end
                S_RECOVER: begin
                    if (i_ALU_flush) begin
                        r_pc    <= w_corrected;
                        r_valid <= 1'b0;
                    end else if (i_Stall) begin
                        r_state <= S_HOLD;
                        r_valid <= 1'b1;
                    end else begin
                        // Bubble slot is skipped; fetch resumes after the corrected PC.
                        r_state <= S_RUN;
                        r_pc    <= w_pc_inc;
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_BOOT;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_btb_valid[i] <= 1'b0;
            end
        end else if (w_btb_we) begin
            r_btb_valid[w_wr_idx] <= 1'b1;
        end
    end

    // NOTE: tag/target storage has no reset; the valid bits alone gate every lookup.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset && w_btb_we) begin
            r_btb_tag[w_wr_idx]    <= w_wr_tag;
            r_btb_target[w_wr_idx] <= i_ALU_target;
        end
    end

`ifdef FETCH_STATS_EN
    logic w_redirect_applied;
    logic w_flush_accepted;
    logic [15:0] r_redirect_count;
    logic [15:0] r_flush_count;

    assign w_redirect_applied = w_redirect & ~i_ALU_flush & ~i_Stall;
    assign w_flush_accepted   = i_ALU_flush & (r_state != S_BOOT);

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_redirect_count <= '0;
            r_flush_count    <= '0;
        end else begin
            if (w_redirect_applied && r_redirect_count != 16'hFFFF)
                r_redirect_count <= r_redirect_count + 16'd1;
            if (w_flush_accepted && r_flush_count != 16'hFFFF)
                r_flush_count <= r_flush_count + 16'd1;
        end
    end

    assign o_redirect_count = r_redirect_count;
    assign o_flush_count    = r_flush_count;
`endif

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed self-checking bench for fetch_pc_sequencer (RESET_PC=0x100, AW=22, 16-entry BTB).
module tb_fetch_pc_sequencer;

    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          bp_taken;
    logic          bp_valid;
    logic          alu_flush;
    logic          alu_isbranch;
    logic          alu_outcome;
    logic [AW-1:0] alu_pc;
    logic [AW-1:0] alu_target;
    logic [AW-1:0] imem_address;
    logic          imem_valid;
    logic          pred_taken;
    logic          btb_hit;
`ifdef FETCH_STATS_EN
    logic [15:0]   redirect_count;
    logic [15:0]   flush_count;
`endif

    int checks        = 0;
    int failures      = 0;
    int exp_redirects = 0;
    int exp_flushes   = 0;

    always #5 clk = ~clk;

    fetch_pc_sequencer #(
        .ADDRESS_WIDTH(AW),
        .BTB_ENTRIES  (16),
        .RESET_PC     (22'h100)
    ) dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Stall       (stall),
        .i_BP_taken    (bp_taken),
        .i_BP_valid    (bp_valid),
        .i_ALU_flush   (alu_flush),
        .i_ALU_isbranch(alu_isbranch),
        .i_ALU_outcome (alu_outcome),
        .i_ALU_pc      (alu_pc),
        .i_ALU_target  (alu_target),
`ifdef FETCH_STATS_EN
        .o_redirect_count(redirect_count),
        .o_flush_count   (flush_count),
`endif
        .o_IMEM_address(imem_address),
        .o_IMEM_valid  (imem_valid),
        .o_pred_taken  (pred_taken),
        .o_btb_hit     (btb_hit)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_alu();
        alu_flush    = 1'b0;
        alu_isbranch = 1'b0;
        alu_outcome  = 1'b0;
        alu_pc       = '0;
        alu_target   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; bp_taken = 1'b1; bp_valid = 1'b1;
        clear_alu();
        step();
        step();
        checks++;
        if (imem_address !== 22'h100 || imem_valid !== 1'b0 || pred_taken !== 1'b0 || btb_hit !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: addr=%h valid=%b pred=%b hit=%b expected 100/0/0/0",
                     imem_address, imem_valid, pred_taken, btb_hit);
        end
        rst = 1'b0; bp_taken = 1'b0; bp_valid = 1'b0;
        step();
        checks++;
        if (imem_address !== 22'h101 || imem_valid !== 1'b1) begin
            failures++;
            $display("FAIL boot_exit: addr=%h valid=%b expected 101/1", imem_address, imem_valid);
        end
        step();
        checks++;
        if (imem_address !== 22'h102 || imem_valid !== 1'b1) begin
            failures++;
            $display("FAIL seq_inc: addr=%h valid=%b expected 102/1", imem_address, imem_valid);
        end
    endtask

    task automatic test_btb_redirect();
        alu_isbranch = 1'b1; alu_outcome = 1'b1; alu_pc = 22'h104; alu_target = 22'h200;
        step();
        clear_alu();
        checks++;
        if (imem_address !== 22'h103 || btb_hit !== 1'b0) begin
            failures++;
            $display("FAIL train_addr: addr=%h hit=%b expected 103/0", imem_address, btb_hit);
        end
        step();
        checks++;
        if (imem_address !== 22'h104 || btb_hit !== 1'b1 || pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL btb_lookup: addr=%h hit=%b pred=%b expected 104/1/0",
                     imem_address, btb_hit, pred_taken);
        end
        bp_valid = 1'b1; bp_taken = 1'b1;
        #1;
        checks++;
        if (pred_taken !== 1'b1) begin
            failures++;
            $display("FAIL pred_taken: got %b expected 1", pred_taken);
        end
        step();
        exp_redirects++;
        checks++;
        if (imem_address !== 22'h200 || imem_valid !== 1'b1) begin
            failures++;
            $display("FAIL redirect_target: addr=%h valid=%b expected 200/1", imem_address, imem_valid);
        end
        // Predicted taken with no BTB entry must fall through.
        checks++;
        if (btb_hit !== 1'b0 || pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL miss_pred: hit=%b pred=%b expected 0/0", btb_hit, pred_taken);
        end
        step();
        bp_valid = 1'b0; bp_taken = 1'b0;
        checks++;
        if (imem_address !== 22'h201) begin
            failures++;
            $display("FAIL miss_fallthrough: addr=%h expected 201", imem_address);
        end
    endtask

    task automatic test_stall();
        alu_flush = 1'b1; alu_outcome = 1'b1; alu_target = 22'h104;
        step();
        exp_flushes++;
        clear_alu();
        checks++;
        if (imem_address !== 22'h104 || imem_valid !== 1'b0 || btb_hit !== 1'b0) begin
            failures++;
            $display("FAIL flush_bubble: addr=%h valid=%b hit=%b expected 104/0/0",
                     imem_address, imem_valid, btb_hit);
        end
        step();
        checks++;
        if (imem_address !== 22'h105 || imem_valid !== 1'b1) begin
            failures++;
            $display("FAIL recover_exit: addr=%h valid=%b expected 105/1", imem_address, imem_valid);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (imem_address !== 22'h105 || imem_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold[%0d]: addr=%h valid=%b expected 105/1", i, imem_address, imem_valid);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if (imem_address !== 22'h106 || imem_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: addr=%h valid=%b expected 106/1", imem_address, imem_valid);
        end
    endtask

    task automatic test_flush_during_stall();
        stall = 1'b1;
        step();
        alu_flush = 1'b1; alu_outcome = 1'b0; alu_pc = 22'h200;
        step();
        exp_flushes++;
        clear_alu();
        stall = 1'b0;
        checks++;
        if (imem_address !== 22'h201 || imem_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_over_stall: addr=%h valid=%b expected 201/0", imem_address, imem_valid);
        end
        step();
        checks++;
        if (imem_address !== 22'h202 || imem_valid !== 1'b1) begin
            failures++;
            $display("FAIL post_bubble: addr=%h valid=%b expected 202/1", imem_address, imem_valid);
        end
    endtask

    task automatic test_flush_in_recover();
        alu_flush = 1'b1; alu_outcome = 1'b0; alu_pc = 22'h300;
        step();
        checks++;
        if (imem_address !== 22'h301 || imem_valid !== 1'b0) begin
            failures++;
            $display("FAIL first_flush: addr=%h valid=%b expected 301/0", imem_address, imem_valid);
        end
        alu_outcome = 1'b1; alu_target = 22'h400;
        step();
        exp_flushes += 2;
        clear_alu();
        checks++;
        if (imem_address !== 22'h400 || imem_valid !== 1'b0) begin
            failures++;
            $display("FAIL reflush_recover: addr=%h valid=%b expected 400/0", imem_address, imem_valid);
        end
        step();
        checks++;
        if (imem_address !== 22'h401 || imem_valid !== 1'b1) begin
            failures++;
            $display("FAIL reflush_exit: addr=%h valid=%b expected 401/1", imem_address, imem_valid);
        end
    endtask

    task automatic test_wrap();
        alu_flush = 1'b1; alu_outcome = 1'b1; alu_target = 22'h3FFFFE;
        step();
        clear_alu();
        step();
        checks++;
        if (imem_address !== 22'h3FFFFF || imem_valid !== 1'b1) begin
            failures++;
            $display("FAIL pc_max: addr=%h valid=%b expected 3fffff/1", imem_address, imem_valid);
        end
        step();
        checks++;
        if (imem_address !== 22'h000000 || imem_valid !== 1'b1) begin
            failures++;
            $display("FAIL pc_wrap: addr=%h valid=%b expected 000000/1", imem_address, imem_valid);
        end
        alu_flush = 1'b1; alu_outcome = 1'b0; alu_pc = 22'h3FFFFF;
        step();
        exp_flushes += 2;
        clear_alu();
        checks++;
        if (imem_address !== 22'h000000 || imem_valid !== 1'b0) begin
            failures++;
            $display("FAIL corrected_wrap: addr=%h valid=%b expected 000000/0", imem_address, imem_valid);
        end
        step();
        checks++;
        if (imem_address !== 22'h000001 || imem_valid !== 1'b1) begin
            failures++;
            $display("FAIL corrected_wrap_exit: addr=%h valid=%b expected 000001/1", imem_address, imem_valid);
        end
    endtask

    task automatic test_same_cycle_write();
        alu_isbranch = 1'b1; alu_outcome = 1'b1; alu_pc = 22'h001; alu_target = 22'h050;
        stall = 1'b1;
        #1;
        checks++;
        if (btb_hit !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle_hit: got %b expected 0", btb_hit);
        end
        step();
        clear_alu();
        checks++;
        if (imem_address !== 22'h001 || btb_hit !== 1'b1) begin
            failures++;
            $display("FAIL next_cycle_hit: addr=%h hit=%b expected 001/1", imem_address, btb_hit);
        end
        bp_valid = 1'b1; bp_taken = 1'b1; stall = 1'b0;
        step();
        exp_redirects++;
        bp_valid = 1'b0; bp_taken = 1'b0;
        checks++;
        if (imem_address !== 22'h050 || imem_valid !== 1'b1) begin
            failures++;
            $display("FAIL redirect_from_hold: addr=%h valid=%b expected 050/1", imem_address, imem_valid);
        end
    endtask

    task automatic test_stats();
`ifdef FETCH_STATS_EN
        checks++;
        if (redirect_count !== 16'(exp_redirects) || flush_count !== 16'(exp_flushes)) begin
            failures++;
            $display("FAIL stats_counts: redirects=%0d flushes=%0d expected %0d/%0d",
                     redirect_count, flush_count, exp_redirects, exp_flushes);
        end
`endif
    endtask

    task automatic test_reset_mid();
        // A training write coincident with reset must be dropped.
        alu_isbranch = 1'b1; alu_outcome = 1'b1; alu_pc = 22'h104; alu_target = 22'h333;
        rst = 1'b1;
        step();
        clear_alu();
        checks++;
        if (imem_address !== 22'h100 || imem_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_state: addr=%h valid=%b expected 100/0", imem_address, imem_valid);
        end
`ifdef FETCH_STATS_EN
        checks++;
        if (redirect_count !== 16'd0 || flush_count !== 16'd0) begin
            failures++;
            $display("FAIL stats_cleared: redirects=%0d flushes=%0d expected 0/0", redirect_count, flush_count);
        end
`endif
        rst = 1'b0;
        step();
        checks++;
        if (imem_address !== 22'h101 || imem_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_boot: addr=%h valid=%b expected 101/1", imem_address, imem_valid);
        end
        alu_flush = 1'b1; alu_outcome = 1'b1; alu_target = 22'h103;
        step();
        clear_alu();
        step();
        checks++;
        if (imem_address !== 22'h104 || imem_valid !== 1'b1 || btb_hit !== 1'b0) begin
            failures++;
            $display("FAIL btb_cleared: addr=%h valid=%b hit=%b expected 104/1/0",
                     imem_address, imem_valid, btb_hit);
        end
    endtask

    initial begin
        test_reset();
        test_btb_redirect();
        test_stall();
        test_flush_during_stall();
        test_flush_in_recover();
        test_wrap();
        test_same_cycle_write();
        test_stats();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
